// File: rtl/mips_if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_if_stage_if
// Purpose  : Bundles the instruction-memory req/ack bus and the IF/ID
//            decode-side signals of the mips_32_bit fetch stage.
// Ports    : master modport -> fetch stage (drives imem_req/imem_addr and the
//                              if_* IF/ID outputs, reads ack/rdata/stall/
//                              redirect)
//            slave modport  -> memory + decode side (the opposite directions)
// Revision : 1.0 - initial release
// ============================================================================
interface mips_if_stage_if;
  // Instruction memory bus
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // Decode / execute control
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  // IF/ID register outputs
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  stall, redirect, redirect_pc,
    output if_valid, if_instr, if_pc, if_pc_plus4
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output stall, redirect, redirect_pc,
    input  if_valid, if_instr, if_pc, if_pc_plus4
  );
endinterface
`default_nettype wire

// File: rtl/mips_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : mips_if_stage
// Purpose  : Instruction-fetch stage. Generates the PC, fetches one
//            instruction at a time over a req/ack memory bus, and presents it
//            to decode through the IF/ID register. A one-entry holding buffer
//            absorbs a fetch that completes while decode is stalled; redirects
//            flush the pipe and discard any wrong-path fetch in flight.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - mips_if_stage_if.master (imem bus, stall/redirect, if_*)
// Revision : 1.0 - initial release
// ============================================================================
module mips_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire              clk,
  input  wire              rst,
  mips_if_stage_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_BLOCKED = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;          // next fetch PC (redirect target while in DISCARD)
  logic [31:0] addr_q;        // address presented on the bus
  logic        req_q;
  logic [31:0] buf_instr_q;   // holding buffer; full exactly when in BLOCKED
  logic [31:0] buf_pc_q;
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc_plus4_q;

  logic        fetch_done;
  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;
  logic        unused_rpc_bits;

  assign fetch_done      = req_q & bus.imem_ack;
  assign pc_inc          = pc_q + 32'd4;
  assign redirect_tgt    = {bus.redirect_pc[31:2], 2'b00};
  assign unused_rpc_bits = &{1'b0, bus.redirect_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      req_q         <= 1'b0;
      buf_instr_q   <= 32'd0;
      buf_pc_q      <= 32'd0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= 32'd0;
      if_pc_plus4_q <= 32'd0;
    end else if (bus.redirect) begin
      // Redirect beats stall: flush IF/ID and the buffer unconditionally.
      if_valid_q <= 1'b0;
      pc_q       <= redirect_tgt;
      if ((state_q == S_RUN || state_q == S_DISCARD) && !fetch_done) begin
        // Request still in flight: keep it on the bus until acked, then drop.
        state_q <= S_DISCARD;
      end else begin
        state_q <= S_RUN;
        req_q   <= 1'b1;
        addr_q  <= redirect_tgt;
      end
    end else begin
      // Decode consumed the current entry and nothing replaces it below.
      if (!bus.stall) if_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          state_q <= S_RUN;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end

        S_RUN: begin
          if (fetch_done) begin
            pc_q <= pc_inc;
            if (!if_valid_q || !bus.stall) begin
              if_valid_q    <= 1'b1;
              if_instr_q    <= bus.imem_rdata;
              if_pc_q       <= pc_q;
              if_pc_plus4_q <= pc_inc;
              addr_q        <= pc_inc;
            end else begin
              buf_instr_q <= bus.imem_rdata;
              buf_pc_q    <= pc_q;
              req_q       <= 1'b0;
              state_q     <= S_BLOCKED;
            end
          end
        end

        S_BLOCKED: begin
          if (!bus.stall) begin
            if_valid_q    <= 1'b1;
            if_instr_q    <= buf_instr_q;
            if_pc_q       <= buf_pc_q;
            if_pc_plus4_q <= buf_pc_q + 32'd4;
            req_q         <= 1'b1;
            addr_q        <= pc_q;
            state_q       <= S_RUN;
          end
        end

        S_DISCARD: begin
          // Wrong-path data is ignored; resume at the saved target.
          if (fetch_done) begin
            addr_q  <= pc_q;
            state_q <= S_RUN;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus4 = if_pc_plus4_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_if_stage
// Purpose  : Directed self-checking bench for mips_if_stage. Memory returns
//            a fixed pattern derived from the address; ack is driven by the
//            stimulus sequence to create zero-wait, wait-state and
//            outstanding-request situations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_if_stage;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  mips_if_stage_if bus ();

  mips_if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_rdata = instr_of(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock, then settle on the falling edge for checks and new inputs.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst             = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;

    // ---------------- reset state
    step();
    chk("rst_req",   bus.imem_req,    32'd0);
    chk("rst_valid", bus.if_valid,    32'd0);
    chk("rst_instr", bus.if_instr,    32'd0);
    chk("rst_pc",    bus.if_pc,       32'd0);
    chk("rst_pc4",   bus.if_pc_plus4, 32'd0);

    // ---------------- zero-wait streaming
    bus.imem_ack = 1'b1;
    rst = 1'b0;
    step();
    chk("zw_req1",   bus.imem_req,  32'd1);
    chk("zw_addr0",  bus.imem_addr, 32'h0);
    chk("zw_nv",     bus.if_valid,  32'd0);
    step();
    chk("zw_valid",  bus.if_valid,    32'd1);
    chk("zw_pc0",    bus.if_pc,       32'h0);
    chk("zw_pc4",    bus.if_pc_plus4, 32'h4);
    chk("zw_instr0", bus.if_instr,    instr_of(32'h0));
    chk("zw_addr4",  bus.imem_addr,   32'h4);
    step();
    chk("zw_pc_4",   bus.if_pc,     32'h4);
    chk("zw_addr8",  bus.imem_addr, 32'h8);
    step();
    chk("zw_pc_8",   bus.if_pc,     32'h8);
    chk("zw_addrC",  bus.imem_addr, 32'hC);

    // ---------------- two wait states per fetch
    bus.imem_ack = 1'b0;
    step();
    chk("ws_v0a",    bus.if_valid,  32'd0);
    chk("ws_addrCa", bus.imem_addr, 32'hC);
    step();
    chk("ws_addrCb", bus.imem_addr, 32'hC);
    chk("ws_reqb",   bus.imem_req,  32'd1);
    bus.imem_ack = 1'b1;
    step();
    chk("ws_v1",     bus.if_valid,  32'd1);
    chk("ws_pcC",    bus.if_pc,     32'hC);
    chk("ws_instrC", bus.if_instr,  instr_of(32'hC));
    chk("ws_addr10", bus.imem_addr, 32'h10);
    bus.imem_ack = 1'b0;
    step();
    chk("ws_v0b",    bus.if_valid,  32'd0);
    step();
    chk("ws_addr10b", bus.imem_addr, 32'h10);
    bus.imem_ack = 1'b1;
    step();
    chk("ws_pc10",   bus.if_pc,     32'h10);
    chk("ws_v1b",    bus.if_valid,  32'd1);
    chk("ws_addr14", bus.imem_addr, 32'h14);

    // ---------------- stall fills the holding buffer
    bus.stall = 1'b1;
    step();
    chk("st_req0",   bus.imem_req, 32'd0);
    chk("st_valid",  bus.if_valid, 32'd1);
    chk("st_pc10",   bus.if_pc,    32'h10);
    step();
    step();
    step();
    chk("st_req0b",  bus.imem_req, 32'd0);
    chk("st_pc10b",  bus.if_pc,    32'h10);
    chk("st_instr",  bus.if_instr, instr_of(32'h10));
    bus.stall = 1'b0;
    step();
    chk("st_buf_pc",  bus.if_pc,       32'h14);
    chk("st_buf_ins", bus.if_instr,    instr_of(32'h14));
    chk("st_buf_p4",  bus.if_pc_plus4, 32'h18);
    chk("st_buf_v",   bus.if_valid,    32'd1);
    chk("st_addr18",  bus.imem_addr,   32'h18);
    step();
    chk("st_pc18",   bus.if_pc,     32'h18);
    chk("st_addr1C", bus.imem_addr, 32'h1C);

    // ---------------- redirect with an unacked request at 0x20
    step();
    chk("rd_pc1C",   bus.if_pc,     32'h1C);
    chk("rd_addr20", bus.imem_addr, 32'h20);
    bus.imem_ack    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    step();
    bus.redirect = 1'b0;
    chk("rd_req",     bus.imem_req,  32'd1);
    chk("rd_hold20",  bus.imem_addr, 32'h20);
    chk("rd_v0",      bus.if_valid,  32'd0);
    step();
    chk("rd_hold20b", bus.imem_addr, 32'h20);
    chk("rd_v0b",     bus.if_valid,  32'd0);
    bus.imem_ack = 1'b1;
    step();
    chk("rd_drop_v0", bus.if_valid,  32'd0);
    chk("rd_addr100", bus.imem_addr, 32'h100);
    chk("rd_req100",  bus.imem_req,  32'd1);
    step();
    chk("rd_v1",      bus.if_valid,    32'd1);
    chk("rd_pc100",   bus.if_pc,       32'h100);
    chk("rd_ins100",  bus.if_instr,    instr_of(32'h100));
    chk("rd_p4_104",  bus.if_pc_plus4, 32'h104);

    // ---------------- redirect + stall while the buffer is full
    bus.stall = 1'b1;
    step();
    chk("rs_req0",    bus.imem_req, 32'd0);
    chk("rs_pc100",   bus.if_pc,    32'h100);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step();
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    chk("rs_v0",      bus.if_valid,  32'd0);
    chk("rs_req1",    bus.imem_req,  32'd1);
    chk("rs_addr200", bus.imem_addr, 32'h200);
    step();
    chk("rs_v1",      bus.if_valid, 32'd1);
    chk("rs_pc200",   bus.if_pc,    32'h200);
    chk("rs_ins200",  bus.if_instr, instr_of(32'h200));

    // ---------------- asynchronous reset mid-wait
    bus.imem_ack = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("ar_req0",  bus.imem_req,  32'd0);
    chk("ar_v0",    bus.if_valid,  32'd0);
    chk("ar_pc0",   bus.if_pc,     32'd0);
    chk("ar_ins0",  bus.if_instr,  32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ar_req1",  bus.imem_req,  32'd1);
    chk("ar_addr0", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b1;
    step();
    chk("ar_v1",    bus.if_valid,  32'd1);
    chk("ar_pc_0",  bus.if_pc,     32'h0);

    // ---------------- redirect on an acking edge, PC wrap at 2^32
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    step();
    bus.redirect = 1'b0;
    chk("wr_v0",     bus.if_valid,  32'd0);
    chk("wr_addr",   bus.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_v1",     bus.if_valid,    32'd1);
    chk("wr_pc",     bus.if_pc,       32'hFFFF_FFFC);
    chk("wr_pc4",    bus.if_pc_plus4, 32'h0);
    chk("wr_addr0",  bus.imem_addr,   32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
